// File: rtl/idma_inoc_pkg.sv
// Shared definitions for the input-buffer ping-pong controller.
//   NUM_BANKS    : number of ibuffer banks (ping and pong)
//   bank_state_e : per-bank lifecycle EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY
package idma_inoc_pkg;

  localparam int NUM_BANKS = 2;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_e;

endpackage

// File: rtl/idma_ibuffer_bank_fsm.sv
// State register and transitions for a single ibuffer bank.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   clear        : flush; forces EMPTY with priority over every event
//   grant        : bank granted to the DMA writer   (EMPTY    -> FILLING)
//   fill_done    : writer finished this bank        (FILLING  -> FULL)
//   start        : reader begins draining this bank (FULL     -> DRAINING)
//   drain_done   : reader finished this bank        (DRAINING -> EMPTY)
//   state        : registered state (also the debug view of this FSM)
//   state_next   : combinational next state, used by the top to keep
//                  full_cnt registered in step with state
// Events arriving in a state where they do not apply are ignored here;
// the top decides whether such an event is a protocol error.
module idma_ibuffer_bank_fsm
  import idma_inoc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       grant,
  input  logic       fill_done,
  input  logic       start,
  input  logic       drain_done,
  output logic [1:0] state,
  output logic [1:0] state_next
);

  bank_state_e cur;
  bank_state_e nxt;

  always_comb begin
    nxt = cur;
    if (clear) begin
      nxt = BANK_EMPTY;
    end else begin
      case (cur)
        BANK_EMPTY:    if (grant)      nxt = BANK_FILLING;
        BANK_FILLING:  if (fill_done)  nxt = BANK_FULL;
        BANK_FULL:     if (start)      nxt = BANK_DRAINING;
        BANK_DRAINING: if (drain_done) nxt = BANK_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= BANK_EMPTY;
    end else begin
      cur <= nxt;
    end
  end

  assign state      = cur;
  assign state_next = nxt;

endmodule

// File: rtl/idma_ibuffer_pingpong_ctrl.sv
// Ping-pong controller for a two-bank input buffer. A DMA writer fills one
// bank while a reader drains the other; banks are filled and drained in
// strictly alternating order.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   enable                  : allows new grants/starts (in-flight work completes regardless)
//   flush                   : abort; empties both banks, zeroes pointers, pulses and seq_err
//   dma_rd_req              : writer request, level, held until dma_grant
//   dma_write_done          : pulse, the FILLING bank is complete
//   dma_grant               : one-cycle grant pulse
//   dma_bank, dma_base_addr : granted bank and its base word address {bank, zeros}
//   rd_start                : one-cycle drain-start pulse
//   rd_bank, rd_base_addr   : bank being drained and its base word address
//   return_done             : pulse, the DRAINING bank is complete
//   bank_state              : [1:0] bank 0, [3:2] bank 1 (EMPTY/FILLING/FULL/DRAINING)
//   full_cnt                : number of banks currently FULL
//   seq_err                 : sticky; a done pulse arrived with no matching bank busy
//
// Handshake: dma_rd_req is a request level that must stay high until the
// cycle after it is answered by the single-cycle dma_grant pulse. Done
// pulses are single-cycle events with no back-pressure.
module idma_ibuffer_pingpong_ctrl
  import idma_inoc_pkg::*;
#(
  parameter int MEM_AW = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              flush,
  input  logic              dma_rd_req,
  input  logic              dma_write_done,
  output logic              dma_grant,
  output logic              dma_bank,
  output logic [MEM_AW-1:0] dma_base_addr,
  output logic              rd_start,
  output logic              rd_bank,
  output logic [MEM_AW-1:0] rd_base_addr,
  input  logic              return_done,
  output logic [3:0]        bank_state,
  output logic [1:0]        full_cnt,
  output logic              seq_err
);

  logic [1:0] st      [NUM_BANKS];
  logic [1:0] st_next [NUM_BANKS];

  logic wr_ptr;
  logic rd_ptr;
  logic any_filling;
  logic any_draining;
  logic grant_go;
  logic start_go;
  logic fill_ok;
  logic drain_ok;
  logic [1:0] full_next;

  logic [NUM_BANKS-1:0] bank_grant;
  logic [NUM_BANKS-1:0] bank_fill_done;
  logic [NUM_BANKS-1:0] bank_start;
  logic [NUM_BANKS-1:0] bank_drain_done;

  always_comb begin
    any_filling  = 1'b0;
    any_draining = 1'b0;
    full_next    = 2'd0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (st[i] == BANK_FILLING)       any_filling  = 1'b1;
      if (st[i] == BANK_DRAINING)      any_draining = 1'b1;
      if (st_next[i] == BANK_FULL)     full_next    = full_next + 2'd1;
    end
  end

  // Decisions look only at registered state, so a bank that changes state
  // at an edge is considered again one cycle later at the earliest. The
  // dma_grant/rd_start terms stop a second pulse on the cycle right after one.
  assign grant_go = enable & dma_rd_req & ~flush & ~dma_grant & ~any_filling &
                    (st[wr_ptr] == BANK_EMPTY);
  assign start_go = enable & ~flush & ~rd_start & ~any_draining &
                    (st[rd_ptr] == BANK_FULL);

  assign fill_ok  = |bank_fill_done;
  assign drain_ok = |bank_drain_done;

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    assign bank_grant[g]      = grant_go & (wr_ptr == 1'(g));
    assign bank_start[g]      = start_go & (rd_ptr == 1'(g));
    // At most one bank can be FILLING (resp. DRAINING), so a done pulse
    // targets whichever bank is in that state.
    assign bank_fill_done[g]  = dma_write_done & (st[g] == BANK_FILLING);
    assign bank_drain_done[g] = return_done    & (st[g] == BANK_DRAINING);

    idma_ibuffer_bank_fsm u_bank_fsm (
      .clk        (clk),
      .rst        (rst),
      .clear      (flush),
      .grant      (bank_grant[g]),
      .fill_done  (bank_fill_done[g]),
      .start      (bank_start[g]),
      .drain_done (bank_drain_done[g]),
      .state      (st[g]),
      .state_next (st_next[g])
    );

    assign bank_state[2*g +: 2] = st[g];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      dma_grant <= 1'b0;
      rd_start  <= 1'b0;
      dma_bank  <= 1'b0;
      rd_bank   <= 1'b0;
      full_cnt  <= 2'd0;
      seq_err   <= 1'b0;
    end else if (flush) begin
      // dma_bank/rd_bank keep their last value across a flush
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      dma_grant <= 1'b0;
      rd_start  <= 1'b0;
      full_cnt  <= 2'd0;
      seq_err   <= 1'b0;
    end else begin
      dma_grant <= grant_go;
      rd_start  <= start_go;
      if (grant_go) dma_bank <= wr_ptr;
      if (start_go) rd_bank  <= rd_ptr;
      if (fill_ok)  wr_ptr   <= ~wr_ptr;
      if (drain_ok) rd_ptr   <= ~rd_ptr;
      if ((dma_write_done & ~fill_ok) | (return_done & ~drain_ok)) begin
        seq_err <= 1'b1;
      end
      full_cnt <= full_next;
    end
  end

  assign dma_base_addr = {dma_bank, {(MEM_AW-1){1'b0}}};
  assign rd_base_addr  = {rd_bank,  {(MEM_AW-1){1'b0}}};

endmodule

// File: tb/tb_idma_ibuffer_pingpong_ctrl.sv
// Self-checking bench for idma_ibuffer_pingpong_ctrl: a table of per-cycle
// {inputs, expected outputs} records plus a hand-written reset sequence.
module tb_idma_ibuffer_pingpong_ctrl;

  localparam int AW = 15;

  localparam logic [1:0] SE  = 2'd0;
  localparam logic [1:0] SFI = 2'd1;
  localparam logic [1:0] SFU = 2'd2;
  localparam logic [1:0] SD  = 2'd3;

  typedef struct packed {
    logic          gnt;
    logic          db;
    logic [AW-1:0] dbase;
    logic          rs;
    logic          rb;
    logic [AW-1:0] rbase;
    logic [3:0]    st;
    logic [1:0]    fc;
    logic          err;
  } out_t;

  localparam int W = $bits(out_t);

  typedef struct {
    string      name;
    logic       rst;
    logic       en;
    logic       fl;
    logic       req;
    logic       wd;
    logic       rd;
    logic       gnt;
    logic       db;
    logic       rs;
    logic       rb;
    logic [1:0] s0;
    logic [1:0] s1;
    logic [1:0] fc;
    logic       err;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          flush;
  logic          dma_rd_req;
  logic          dma_write_done;
  logic          dma_grant;
  logic          dma_bank;
  logic [AW-1:0] dma_base_addr;
  logic          rd_start;
  logic          rd_bank;
  logic [AW-1:0] rd_base_addr;
  logic          return_done;
  logic [3:0]    bank_state;
  logic [1:0]    full_cnt;
  logic          seq_err;

  always #5 clk = ~clk;

  idma_ibuffer_pingpong_ctrl #(.MEM_AW(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .flush          (flush),
    .dma_rd_req     (dma_rd_req),
    .dma_write_done (dma_write_done),
    .dma_grant      (dma_grant),
    .dma_bank       (dma_bank),
    .dma_base_addr  (dma_base_addr),
    .rd_start       (rd_start),
    .rd_bank        (rd_bank),
    .rd_base_addr   (rd_base_addr),
    .return_done    (return_done),
    .bank_state     (bank_state),
    .full_cnt       (full_cnt),
    .seq_err        (seq_err)
  );

  // ---------------- scoreboard ----------------
  vec_t         vecs[$];
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks   = 0;
  int           failures = 0;

  function automatic logic [W-1:0] pack_exp(vec_t v);
    out_t o;
    o.gnt   = v.gnt;
    o.db    = v.db;
    o.dbase = '0;
    o.dbase[AW-1] = v.db;
    o.rs    = v.rs;
    o.rb    = v.rb;
    o.rbase = '0;
    o.rbase[AW-1] = v.rb;
    o.st    = {v.s1, v.s0};
    o.fc    = v.fc;
    o.err   = v.err;
    return o;
  endfunction

  function automatic string fmt(logic [W-1:0] x);
    out_t o;
    o = out_t'(x);
    return $sformatf("gnt=%0b dbank=%0b dbase=%h start=%0b rbank=%0b rbase=%h state1=%0d state0=%0d full=%0d err=%0b",
                     o.gnt, o.db, o.dbase, o.rs, o.rb, o.rbase, o.st[3:2], o.st[1:0], o.fc, o.err);
  endfunction

  task automatic add(input string n,
                     input logic r, en, fl, req, wd, rd,
                     input logic gnt, db, rs, rb,
                     input logic [1:0] s0, s1, fc,
                     input logic err);
    vec_t v;
    v.name = n; v.rst = r; v.en = en; v.fl = fl; v.req = req; v.wd = wd; v.rd = rd;
    v.gnt = gnt; v.db = db; v.rs = rs; v.rb = rb;
    v.s0 = s0; v.s1 = s1; v.fc = fc; v.err = err;
    vecs.push_back(v);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input vec_t v);
    rst            = v.rst;
    enable         = v.en;
    flush          = v.fl;
    dma_rd_req     = v.req;
    dma_write_done = v.wd;
    return_done    = v.rd;
    exp_q.push_back(pack_exp(v));
    name_q.push_back(v.name);
  endtask

  task automatic check_out();
    logic [W-1:0] act;
    logic [W-1:0] exp;
    string        nm;
    act = {dma_grant, dma_bank, dma_base_addr, rd_start, rd_bank, rd_base_addr,
           bank_state, full_cnt, seq_err};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty: actual %s, required an expected entry", fmt(act));
    end else begin
      exp = exp_q.pop_front();
      nm  = name_q.pop_front();
      if (act !== exp) begin
        failures++;
        $display("FAIL %s: actual %s | required %s", nm, fmt(act), fmt(exp));
      end
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit
  // after the rising edge that consumed them.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic run_one(input string n,
                         input logic r, en, fl, req, wd, rd,
                         input logic gnt, db, rs, rb,
                         input logic [1:0] s0, s1, fc,
                         input logic err);
    vec_t v;
    v.name = n; v.rst = r; v.en = en; v.fl = fl; v.req = req; v.wd = wd; v.rd = rd;
    v.gnt = gnt; v.db = db; v.rs = rs; v.rb = rb;
    v.s0 = s0; v.s1 = s1; v.fc = fc; v.err = err;
    run_vec(v);
  endtask

  // ---------------- test ----------------
  initial begin
    rst = 1'b1; enable = 1'b0; flush = 1'b0;
    dma_rd_req = 1'b0; dma_write_done = 1'b0; return_done = 1'b0;

    //   name                    rst en fl rq wd rd   gnt db rs rb  s0   s1   fc err
    add("reset_0",               1, 0, 0, 0, 0, 0,   0, 0, 0, 0,  SE,  SE,  0, 0);
    add("reset_1",               1, 1, 0, 1, 0, 0,   0, 0, 0, 0,  SE,  SE,  0, 0);
    add("idle",                  0, 1, 0, 0, 0, 0,   0, 0, 0, 0,  SE,  SE,  0, 0);
    add("grant_b0",              0, 1, 0, 1, 0, 0,   1, 0, 0, 0,  SFI, SE,  0, 0);
    add("no_regrant_filling",    0, 1, 0, 1, 0, 0,   0, 0, 0, 0,  SFI, SE,  0, 0);
    add("fill_done_b0",          0, 1, 0, 0, 1, 0,   0, 0, 0, 0,  SFU, SE,  1, 0);
    add("grant_b1_start_b0",     0, 1, 0, 1, 0, 0,   1, 1, 1, 0,  SD,  SFI, 0, 0);
    add("hold_busy",             0, 1, 0, 1, 0, 0,   0, 1, 0, 0,  SD,  SFI, 0, 0);
    add("fill_done_b1",          0, 1, 0, 0, 1, 0,   0, 1, 0, 0,  SD,  SFU, 1, 0);
    add("no_grant_b0_draining",  0, 1, 0, 1, 0, 0,   0, 1, 0, 0,  SD,  SFU, 1, 0);
    add("drain_done_b0",         0, 1, 0, 1, 0, 1,   0, 1, 0, 0,  SE,  SFU, 1, 0);
    add("regrant_b0_start_b1",   0, 1, 0, 1, 0, 0,   1, 0, 1, 1,  SFI, SD,  0, 0);
    add("fill_done_b0_again",    0, 1, 0, 0, 1, 0,   0, 0, 0, 1,  SFU, SD,  1, 0);
    add("spurious_write_done",   0, 1, 0, 0, 1, 0,   0, 0, 0, 1,  SFU, SD,  1, 1);
    add("drain_done_b1",         0, 1, 0, 0, 0, 1,   0, 0, 0, 1,  SFU, SE,  1, 1);
    add("enable_low_blocks",     0, 0, 0, 1, 0, 0,   0, 0, 0, 1,  SFU, SE,  1, 1);
    add("grant_b1_start_b0_2",   0, 1, 0, 1, 0, 0,   1, 1, 1, 0,  SD,  SFI, 0, 1);
    add("fill_done_b1_2",        0, 1, 0, 0, 1, 0,   0, 1, 0, 0,  SD,  SFU, 1, 1);
    add("flush",                 0, 0, 1, 1, 1, 1,   0, 1, 0, 0,  SE,  SE,  0, 0);
    add("spurious_return_done",  0, 1, 0, 0, 0, 1,   0, 1, 0, 0,  SE,  SE,  0, 1);
    add("flush_beats_req",       0, 1, 1, 1, 0, 0,   0, 1, 0, 0,  SE,  SE,  0, 0);
    add("grant_b0_after_flush",  0, 1, 0, 1, 0, 0,   1, 0, 0, 0,  SFI, SE,  0, 0);
    add("fill_done_enable_low",  0, 0, 0, 0, 1, 0,   0, 0, 0, 0,  SFU, SE,  1, 0);
    add("start_held_off",        0, 0, 0, 0, 0, 0,   0, 0, 0, 0,  SFU, SE,  1, 0);
    add("start_on_enable",       0, 1, 0, 0, 0, 0,   0, 0, 1, 0,  SD,  SE,  0, 0);
    add("grant_b1",              0, 1, 0, 1, 0, 0,   1, 1, 0, 0,  SD,  SFI, 0, 0);
    add("both_done_same_cycle",  0, 1, 0, 0, 1, 1,   0, 1, 0, 0,  SE,  SFU, 1, 0);
    add("grant_b0_start_b1_3",   0, 1, 0, 1, 0, 0,   1, 0, 1, 1,  SFI, SD,  0, 0);
    add("hold_b1_draining",      0, 1, 0, 1, 0, 0,   0, 0, 0, 1,  SFI, SD,  0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i]);
    end

    // Reset while bank 1 is draining and bank 0 filling: both are discarded,
    // and the completion pulses that follow are protocol errors.
    run_one("rst_mid_drain",       1, 1, 0, 1, 0, 0,   0, 0, 0, 0,  SE,  SE,  0, 0);
    run_one("late_return_done",    0, 1, 0, 0, 0, 1,   0, 0, 0, 0,  SE,  SE,  0, 1);
    run_one("grant_after_rst",     0, 1, 0, 1, 0, 0,   1, 0, 0, 0,  SFI, SE,  0, 1);
    run_one("fill_after_rst",      0, 1, 0, 1, 1, 0,   0, 0, 0, 0,  SFU, SE,  1, 1);
    run_one("start_after_rst",     0, 1, 0, 0, 0, 0,   0, 0, 1, 0,  SD,  SE,  0, 1);
    run_one("late_write_done",     0, 0, 0, 0, 1, 0,   0, 0, 0, 0,  SD,  SE,  0, 1);

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_leftover: actual %0d entries, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/idma_ibuffer_pingpong_ctrl.md
IDMA_IBUFFER_PINGPONG_CTRL -- requirements
Module: idma_ibuffer_pingpong_ctrl

Interface
REQ-001 SHALL have parameter MEM_AW, default 15, ibuffer word-address width; bank 0 = lower half, bank 1 = upper half.
REQ-002 SHALL have ports: clk  in  1  sole clock; all logic on rising edge.
REQ-003 SHALL have ports: rst  in  1  reset; synchronous and active-high.
REQ-004 SHALL have ports: enable  in  1  permits new grants/starts; flush  in  1  abort pulse.
REQ-005 SHALL have ports: dma_rd_req  in  1  fill request, level, held until granted; dma_write_done  in  1  fill-complete pulse.
REQ-006 SHALL have ports: dma_grant  out  1  one-cycle grant pulse; dma_bank  out  1  granted bank; dma_base_addr  out  MEM_AW  {dma_bank, zeros}.
REQ-007 SHALL have ports: rd_start  out  1  one-cycle drain-start pulse; rd_bank  out  1; rd_base_addr  out  MEM_AW  {rd_bank, zeros}; return_done  in  1  drain-complete pulse.
REQ-008 SHALL have ports: bank_state  out  2x2  per-bank state; full_cnt  out  2  FULL-bank count, 0..2; seq_err  out  1  sticky protocol error.

Function
REQ-009 SHALL keep per-bank state: EMPTY=0, FILLING=1, FULL=2, DRAINING=3.
REQ-010 SHALL keep wr_ptr (next bank to fill) and rd_ptr (next bank to drain); both start at 0; banks fill and drain strictly in alternating order.
REQ-011 Grant rule: dma_grant SHALL pulse at edge t+1 when, in cycle t, enable=1, dma_rd_req=1, registered bank_state[wr_ptr]=EMPTY, no bank FILLING and dma_grant=0 in cycle t; the same edge SHALL set that bank to FILLING and latch dma_bank=wr_ptr.
REQ-012 dma_write_done in cycle t SHALL set the FILLING bank to FULL and toggle wr_ptr at edge t+1.
REQ-013 Start rule: rd_start SHALL pulse at edge t+1 when, in cycle t, enable=1, registered bank_state[rd_ptr]=FULL, no bank DRAINING and rd_start=0 in cycle t; the same edge SHALL set that bank to DRAINING and latch rd_bank=rd_ptr.
REQ-014 return_done in cycle t SHALL set the DRAINING bank to EMPTY and toggle rd_ptr at edge t+1.
REQ-015 All decisions SHALL use registered state only: a bank freed or filled at edge t can be re-granted or started no earlier than edge t+1 (min 1 idle cycle per bank turnaround).
REQ-016 Fill and drain on different banks SHALL proceed concurrently; grant and start at the same edge SHALL both be allowed.
REQ-017 enable=0 SHALL block new grants and starts only; in-flight fill and drain still complete on their done pulses.
REQ-018 dma_write_done with no bank FILLING, or return_done with no bank DRAINING, SHALL be ignored for state and SHALL set seq_err.
REQ-019 dma_write_done and return_done in the same cycle SHALL both be applied at the same edge.
REQ-020 full_cnt SHALL equal the count of banks in FULL, registered, consistent with bank_state in the same cycle.
REQ-021 flush (priority over all other inputs) SHALL at the next edge force both banks EMPTY, both pointers 0, all pulses 0, and clear seq_err; later done pulses SHALL be treated per REQ-018.
REQ-022 dma_bank, rd_bank and base addresses SHALL hold their last latched value between grants/starts.

Reset
REQ-023 rst=1 at an edge SHALL apply the REQ-021 state; additionally dma_bank=0, rd_bank=0, both base addrs 0, full_cnt=0, seq_err=0, dma_grant=0, rd_start=0.
REQ-024 Reset asserted mid-fill or mid-drain SHALL discard it with no completion pulse required.

Structure
REQ-025 Bank-state enum, state encodings and bank count SHALL live in shared package idma_inoc_pkg.
REQ-026 Per-bank state register and transition logic SHALL be one sub-module, idma_ibuffer_bank_fsm, instantiated twice; pointers and arbitration stay at top.

Verification
REQ-027 After reset, dma_rd_req=1 at cycle 2 -> dma_grant at edge 3, dma_bank=0, dma_base_addr=0x0000, bank_state[0]=FILLING.
REQ-028 Bank 0 filled, then bank 1 granted -> rd_start for bank 0 and dma_grant for bank 1 at the same edge, rd_base_addr=0x0000, dma_base_addr=0x4000.
REQ-029 Both banks FULL, dma_rd_req=1 -> no grant, full_cnt=2; return_done for bank 0 -> grant of bank 0 exactly 1 cycle after bank 0 is EMPTY.
REQ-030 return_done with no bank DRAINING -> seq_err=1 and bank_state unchanged; flush -> seq_err=0, both banks EMPTY.
REQ-031 enable=0 during fill of bank 0, write_done arrives -> bank 0 FULL, no rd_start until enable=1, then rd_start next edge.
REQ-032 rst=1 while bank 1 DRAINING -> next edge all outputs at reset values; later return_done -> seq_err=1.
